// File: rtl/otter_csr_irq.sv
// ---------------------------------------------------------------------------
// otter_csr_irq
// Machine-mode CSR file plus multi-source interrupt controller for the OTTER
// multicycle core. It raises INT_REQ; the CU_FSM answers with INT_ACK at an
// instruction boundary, and TRAP_VEC / CSR_MEPC feed the PC mux.
//
// Ports
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   IRQ        in   raw asynchronous interrupt lines (source i -> mip/mie bit 16+i)
//   CSR_ADDR   in   CSR address (ir[31:20])
//   CSR_OP     in   00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC (applied on the clock edge)
//   CSR_WD     in   write operand (rs1 or zimm)
//   CSR_RD     out  combinational read of CSR_ADDR, value before the write
//   PC         in   PC to resume at after the trap
//   INT_ACK    in   FSM takes the trap this cycle (ignored unless INT_REQ=1)
//   MRET_EXEC  in   mret executing this cycle
//   INT_REQ    out  interrupt request to the FSM
//   TRAP_VEC   out  trap target PC
//   CSR_MEPC   out  mepc, return target for mret
//   MIE_GLOBAL out  mstatus.MIE
// ---------------------------------------------------------------------------
module otter_csr_irq #(
  parameter int                  NUM_IRQ     = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0]  EDGE_MASK   = {NUM_IRQ{1'b1}},
  parameter logic [31:0]         MTVEC_RESET = 32'h0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [11:0]        CSR_ADDR,
  input  logic [1:0]         CSR_OP,
  input  logic [31:0]        CSR_WD,
  output logic [31:0]        CSR_RD,
  input  logic [31:0]        PC,
  input  logic               INT_ACK,
  input  logic               MRET_EXEC,
  output logic               INT_REQ,
  output logic [31:0]        TRAP_VEC,
  output logic [31:0]        CSR_MEPC,
  output logic               MIE_GLOBAL
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] IRQ_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_sPrev;
  logic [NUM_IRQ-1:0] r_pend;
  logic               r_mstatusMie;
  logic               r_mstatusMpie;
  logic [31:0]        r_mie;
  logic [31:0]        r_mtvec;
  logic [31:0]        r_mepc;
  logic [31:0]        r_mcause;

  logic [NUM_IRQ-1:0] w_s;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_winOneHot;
  logic [NUM_IRQ-1:0] w_ackClr;
  logic [NUM_IRQ-1:0] w_mipClr;
  logic [3:0]         w_winIdx;
  logic [4:0]         w_cause;
  logic [31:0]        w_mip;
  logic [31:0]        w_mstatus;
  logic [31:0]        w_new;
  logic [31:0]        w_base;
  logic               w_take;
  logic               w_wen;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_sPrev;
  assign w_mip     = 32'(r_pend) << 16;
  assign w_mstatus = {24'b0, r_mstatusMpie, 3'b0, r_mstatusMie, 3'b0};
  assign w_active  = r_pend & r_mie[16 +: NUM_IRQ];
  assign INT_REQ   = r_mstatusMie & (|w_active);
  assign w_take    = INT_ACK & INT_REQ;
  assign w_wen     = (CSR_OP != 2'b00);
  assign w_cause   = 5'd16 + {1'b0, w_winIdx};
  assign w_ackClr  = w_take ? (w_winOneHot & EDGE_MASK) : '0;
  assign w_mipClr  = (w_wen && CSR_ADDR == ADDR_MIP) ? ~w_new[16 +: NUM_IRQ] : '0;
  assign w_base    = {r_mtvec[31:2], 2'b00};

  assign MIE_GLOBAL = r_mstatusMie;
  assign CSR_MEPC   = r_mepc;

  // Fixed priority: the lowest enabled-and-pending source wins.
  always_comb begin
    w_winIdx    = '0;
    w_winOneHot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_winIdx       = 4'(i);
        w_winOneHot    = '0;
        w_winOneHot[i] = 1'b1;
      end
    end
  end

  // Vectored mode only offsets when a source is actually active.
  always_comb begin
    TRAP_VEC = w_base;
    if (r_mtvec[1:0] == 2'b01 && (|w_active))
      TRAP_VEC = w_base + {25'b0, w_cause, 2'b00};
  end

  // Read mux; unimplemented addresses read zero.
  always_comb begin
    CSR_RD = 32'h0;
    case (CSR_ADDR)
      ADDR_MSTATUS: CSR_RD = w_mstatus;
      ADDR_MIE:     CSR_RD = r_mie;
      ADDR_MTVEC:   CSR_RD = r_mtvec;
      ADDR_MEPC:    CSR_RD = r_mepc;
      ADDR_MCAUSE:  CSR_RD = r_mcause;
      ADDR_MIP:     CSR_RD = w_mip;
      default:      CSR_RD = 32'h0;
    endcase
  end

  // Read-modify-write value shared by all CSRs; each register masks it.
  always_comb begin
    w_new = CSR_RD;
    case (CSR_OP)
      2'b01:   w_new = CSR_WD;
      2'b10:   w_new = CSR_RD | CSR_WD;
      2'b11:   w_new = CSR_RD & ~CSR_WD;
      default: w_new = CSR_RD;
    endcase
  end

  // Input synchronisers plus edge history for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync  <= '0;
      r_sPrev <= '0;
    end else begin
      r_sync[0] <= IRQ;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_sync[k] <= r_sync[k-1];
      r_sPrev <= w_s;
    end
  end

  // Pending bits: edge sources latch rises (a same-cycle set beats any
  // clear), level sources simply mirror the synchronised line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_pend <= '0;
    else
      r_pend <= ((((r_pend & ~w_mipClr & ~w_ackClr) | w_rise)) & EDGE_MASK)
              | (w_s & ~EDGE_MASK);
  end

  // Trap entry outranks mret, which outranks a software write to mstatus.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mstatusMie  <= 1'b0;
      r_mstatusMpie <= 1'b0;
      r_mepc        <= 32'h0;
      r_mcause      <= 32'h0;
    end else if (w_take) begin
      r_mstatusMpie <= r_mstatusMie;
      r_mstatusMie  <= 1'b0;
      r_mepc        <= PC & ~32'h3;
      r_mcause      <= {1'b1, 26'b0, w_cause};
    end else begin
      if (MRET_EXEC) begin
        r_mstatusMie  <= r_mstatusMpie;
        r_mstatusMpie <= 1'b1;
      end else if (w_wen && CSR_ADDR == ADDR_MSTATUS) begin
        r_mstatusMie  <= w_new[3];
        r_mstatusMpie <= w_new[7];
      end
      if (w_wen && CSR_ADDR == ADDR_MEPC)
        r_mepc <= w_new & ~32'h3;
      if (w_wen && CSR_ADDR == ADDR_MCAUSE)
        r_mcause <= w_new;
    end
  end

  // mie and mtvec are never blocked by trap entry. A mode field of 1x
  // is not a legal mode, so the previous mode is kept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mie   <= 32'h0;
      r_mtvec <= MTVEC_RESET;
    end else begin
      if (w_wen && CSR_ADDR == ADDR_MIE)
        r_mie <= w_new & IRQ_MASK;
      if (w_wen && CSR_ADDR == ADDR_MTVEC)
        r_mtvec <= {w_new[31:2], (w_new[1] ? r_mtvec[1:0] : w_new[1:0])};
    end
  end

endmodule

// File: tb/tb_otter_csr_irq.sv
`timescale 1ns/1ps
module tb_otter_csr_irq;

  localparam logic [31:0] MTV_RST = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  IRQ = 4'b0;
  logic [11:0] CSR_ADDR = 12'h0;
  logic [1:0]  CSR_OP = 2'b0;
  logic [31:0] CSR_WD = 32'h0;
  logic [31:0] CSR_RD;
  logic [31:0] PC = 32'h0;
  logic        INT_ACK = 1'b0;
  logic        MRET_EXEC = 1'b0;
  logic        INT_REQ;
  logic [31:0] TRAP_VEC;
  logic [31:0] CSR_MEPC;
  logic        MIE_GLOBAL;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] expPre;
    logic [31:0] expPost;
  } csrVec_t;

  csrVec_t vecs[12];

  // Source 1 is level-sensitive so the level behaviour can be exercised.
  otter_csr_irq #(
    .NUM_IRQ(4), .SYNC_STAGES(2), .EDGE_MASK(4'b1101), .MTVEC_RESET(MTV_RST)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .IRQ(IRQ), .CSR_ADDR(CSR_ADDR), .CSR_OP(CSR_OP),
    .CSR_WD(CSR_WD), .CSR_RD(CSR_RD), .PC(PC), .INT_ACK(INT_ACK),
    .MRET_EXEC(MRET_EXEC), .INT_REQ(INT_REQ), .TRAP_VEC(TRAP_VEC),
    .CSR_MEPC(CSR_MEPC), .MIE_GLOBAL(MIE_GLOBAL)
  );

  // 100 ns period leaves room for several #1 settle steps inside a cycle.
  always #50 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    CSR_OP   = op;
    CSR_ADDR = addr;
    CSR_WD   = wd;
    #1;
  endtask

  task automatic csrWrite(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    applyStimulus(op, addr, wd);
    tick;
    applyStimulus(2'b00, addr, 32'h0);
  endtask

  task automatic readCsr(input string name, input logic [11:0] addr, input logic [31:0] exp);
    applyStimulus(2'b00, addr, 32'h0);
    checkOutput(name, CSR_RD, exp);
  endtask

  task automatic doReset;
    RST_N = 1'b0; IRQ = 4'b0; INT_ACK = 1'b0; MRET_EXEC = 1'b0;
    applyStimulus(2'b00, 12'h0, 32'h0);
    repeat (2) tick;
    RST_N = 1'b1;
    tick;
  endtask

  // Raise the given lines for one cycle; caller counts the remaining edges.
  task automatic pulseIrq(input logic [3:0] lines);
    IRQ = lines;
    tick;
    IRQ = 4'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 12'h305, 32'h0000_1001, MTV_RST,       32'h0000_1001};
    vecs[1]  = '{2'b01, 12'h305, 32'h0000_2002, 32'h0000_1001, 32'h0000_2001};
    vecs[2]  = '{2'b11, 12'h305, 32'h0000_0001, 32'h0000_2001, 32'h0000_2000};
    vecs[3]  = '{2'b01, 12'h341, 32'h1234_5677, 32'h0,         32'h1234_5674};
    vecs[4]  = '{2'b10, 12'h341, 32'h0000_0003, 32'h1234_5674, 32'h1234_5674};
    vecs[5]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0,         32'h000F_0000};
    vecs[6]  = '{2'b11, 12'h304, 32'h0005_0000, 32'h000F_0000, 32'h000A_0000};
    vecs[7]  = '{2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0,         32'h0000_0088};
    vecs[8]  = '{2'b11, 12'h300, 32'h0000_0008, 32'h0000_0088, 32'h0000_0080};
    vecs[9]  = '{2'b01, 12'h342, 32'h8000_001F, 32'h0,         32'h8000_001F};
    vecs[10] = '{2'b01, 12'h7C0, 32'hFFFF_FFFF, 32'h0,         32'h0};
    vecs[11] = '{2'b10, 12'h344, 32'hFFFF_FFFF, 32'h0,         32'h0};

    // Reset held with all IRQ lines high: nothing may leak through.
    RST_N = 1'b0;
    IRQ = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick;
      checkOutput("rst_intreq", {31'b0, INT_REQ}, 32'h0);
    end
    readCsr("rst_mstatus", 12'h300, 32'h0);
    readCsr("rst_mie",     12'h304, 32'h0);
    readCsr("rst_mtvec",   12'h305, MTV_RST);
    readCsr("rst_mepc",    12'h341, 32'h0);
    readCsr("rst_mcause",  12'h342, 32'h0);
    readCsr("rst_mip",     12'h344, 32'h0);
    checkOutput("rst_mieglobal", {31'b0, MIE_GLOBAL}, 32'h0);
    checkOutput("rst_csrmepc", CSR_MEPC, 32'h0);
    checkOutput("rst_trapvec", TRAP_VEC, MTV_RST);
    doReset;

    // CSR read/modify/write semantics from the vector table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wd);
      checkOutput($sformatf("vec%0d_pre", i), CSR_RD, vecs[i].expPre);
      tick;
      applyStimulus(2'b00, vecs[i].addr, 32'h0);
      checkOutput($sformatf("vec%0d_post", i), CSR_RD, vecs[i].expPost);
    end
    doReset;

    // Edge interrupt latency and trap entry.
    csrWrite(2'b10, 12'h300, 32'h8);
    csrWrite(2'b01, 12'h304, 32'h0001_0000);
    pulseIrq(4'b0001);
    checkOutput("lat_e1", {31'b0, INT_REQ}, 32'h0);
    tick;
    checkOutput("lat_e2", {31'b0, INT_REQ}, 32'h0);
    tick;
    checkOutput("lat_e3", {31'b0, INT_REQ}, 32'h1);
    checkOutput("direct_vec", TRAP_VEC, MTV_RST);
    PC = 32'h0000_0122;
    INT_ACK = 1'b1;
    tick;
    INT_ACK = 1'b0;
    checkOutput("ack_mepc", CSR_MEPC, 32'h0000_0120);
    readCsr("ack_mcause", 12'h342, 32'h8000_0010);
    readCsr("ack_mstatus", 12'h300, 32'h0000_0080);
    readCsr("ack_mip", 12'h344, 32'h0);
    checkOutput("ack_intreq", {31'b0, INT_REQ}, 32'h0);

    // mret restores MIE; a spurious ack without a request does nothing.
    MRET_EXEC = 1'b1;
    tick;
    MRET_EXEC = 1'b0;
    readCsr("mret_mstatus", 12'h300, 32'h0000_0088);
    PC = 32'h0000_0500;
    INT_ACK = 1'b1;
    tick;
    INT_ACK = 1'b0;
    checkOutput("noreq_ack_mepc", CSR_MEPC, 32'h0000_0120);
    checkOutput("noreq_ack_mie", {31'b0, MIE_GLOBAL}, 32'h1);

    // Ack and mret together: the ack wins.
    pulseIrq(4'b0001);
    tick;
    tick;
    checkOutput("req2", {31'b0, INT_REQ}, 32'h1);
    PC = 32'h0000_0200;
    INT_ACK = 1'b1;
    MRET_EXEC = 1'b1;
    tick;
    INT_ACK = 1'b0;
    MRET_EXEC = 1'b0;
    checkOutput("ackmret_mie", {31'b0, MIE_GLOBAL}, 32'h0);
    readCsr("ackmret_mstatus", 12'h300, 32'h0000_0080);
    checkOutput("ackmret_mepc", CSR_MEPC, 32'h0000_0200);

    // Asynchronous reset mid-cycle.
    RST_N = 1'b0;
    #1;
    checkOutput("async_mepc", CSR_MEPC, 32'h0);
    readCsr("async_mstatus", 12'h300, 32'h0);
    doReset;

    // Priority and vectored mtvec.
    csrWrite(2'b01, 12'h305, 32'h0000_1001);
    csrWrite(2'b01, 12'h304, 32'h000C_0000);
    csrWrite(2'b10, 12'h300, 32'h8);
    pulseIrq(4'b1100);
    tick;
    tick;
    checkOutput("prio_req", {31'b0, INT_REQ}, 32'h1);
    checkOutput("prio_vec18", TRAP_VEC, 32'h0000_1048);
    csrWrite(2'b11, 12'h304, 32'h0004_0000);
    checkOutput("prio_vec19", TRAP_VEC, 32'h0000_104C);
    PC = 32'h0000_0040;
    INT_ACK = 1'b1;
    tick;
    INT_ACK = 1'b0;
    readCsr("prio_mcause", 12'h342, 32'h8000_0013);
    readCsr("prio_mip", 12'h344, 32'h0004_0000);
    doReset;

    // Level source follows the line and ignores writes.
    IRQ = 4'b0010;
    repeat (3) tick;
    readCsr("lvl_set", 12'h344, 32'h0002_0000);
    csrWrite(2'b11, 12'h344, 32'h0002_0000);
    readCsr("lvl_rc", 12'h344, 32'h0002_0000);
    IRQ = 4'b0000;
    tick;
    tick;
    readCsr("lvl_e2", 12'h344, 32'h0002_0000);
    tick;
    readCsr("lvl_e3", 12'h344, 32'h0);
    doReset;

    // Edge set and software clear on the same cycle: set wins.
    pulseIrq(4'b0001);
    tick;
    tick;
    readCsr("edge_pend", 12'h344, 32'h0001_0000);
    pulseIrq(4'b0001);
    tick;
    applyStimulus(2'b11, 12'h344, 32'h0001_0000);
    tick;
    readCsr("setwins", 12'h344, 32'h0001_0000);
    csrWrite(2'b11, 12'h344, 32'h0001_0000);
    readCsr("rc_clears", 12'h344, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
